// File: rtl/snow3g_pkg.sv
// Shared definitions for the SNOW 3G keystream controller slice.
//   ks_state_e          : controller state encoding
//   WORD_W              : keystream word width
//   DEFAULT_INIT_ROUNDS : init-mode clocks applied after key/IV load
package snow3g_pkg;

  localparam int unsigned WORD_W              = 32;
  localparam int unsigned DEFAULT_INIT_ROUNDS = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT,
    ST_DISCARD,
    ST_RUN,
    ST_DONE
  } ks_state_e;

endpackage

// File: rtl/snow3g_ks_ctrl.sv
// Sequencing controller for the SNOW 3G keystream core (LFSR + R1/R2/R3 FSM).
// Runs a session as load -> INIT_ROUNDS init-mode clocks -> one discarded
// clock -> keystream words released one per valid/ready handshake.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, num_words     : session request and word count (sampled in IDLE)
//   abort                : synchronous cancel of the current session
//   busy, done           : session status / completion pulse
//   core_load/clear/init_mode/step : core control strobes
//   core_z               : keystream word from the core
//   ks_data/valid/ready  : keystream output handshake
module snow3g_ks_ctrl
  import snow3g_pkg::*;
#(
  parameter int unsigned INIT_ROUNDS = DEFAULT_INIT_ROUNDS,
  parameter int unsigned LEN_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              abort,
  output logic              busy,
  output logic              core_load,
  output logic              core_clear,
  output logic              core_init_mode,
  output logic              core_step,
  input  logic [WORD_W-1:0] core_z,
  output logic [WORD_W-1:0] ks_data,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic              done
);

  localparam int unsigned      RND_W      = $clog2(INIT_ROUNDS + 1);
  localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(INIT_ROUNDS - 1);

  ks_state_e        state_q, state_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             handshake;

  always_comb begin
    handshake   = (state_q == ST_RUN) && ks_ready;
    state_d     = state_q;
    round_d     = round_q;
    remaining_d = remaining_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            remaining_d = num_words;
            state_d     = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        round_d = '0;
        state_d = ST_INIT;
      end
      ST_INIT: begin
        if (round_q == LAST_ROUND) begin
          round_d = '0;
          state_d = ST_DISCARD;
        end else begin
          round_d = round_q + 1'b1;
        end
      end
      ST_DISCARD: state_d = ST_RUN;
      ST_RUN: begin
        if (handshake) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every transition outside IDLE (so start still wins in IDLE).
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      round_d     = '0;
      remaining_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      remaining_q <= remaining_d;
    end
  end

  // Moore outputs; core_step additionally follows the RUN handshake and is
  // suppressed in an abort cycle so the core never advances past a cancel.
  always_comb begin
    busy           = (state_q != ST_IDLE);
    core_load      = (state_q == ST_LOAD);
    core_clear     = (state_q == ST_LOAD);
    core_init_mode = (state_q == ST_INIT);
    ks_valid       = (state_q == ST_RUN);
    ks_data        = ks_valid ? core_z : '0;
    done           = (state_q == ST_DONE);
    core_step      = !abort && ((state_q == ST_INIT) || (state_q == ST_DISCARD) || handshake);
  end

endmodule

// File: tb/tb_snow3g_ks_ctrl.sv
// Self-checking bench for snow3g_ks_ctrl with a stand-in keystream core whose
// init-mode and normal-mode step functions differ, so miscounted rounds show up.
module tb_snow3g_ks_ctrl;
  import snow3g_pkg::*;

  localparam int unsigned LEN_W    = 16;
  localparam int          N_ROUNDS = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  num_words = '0;
  logic              abort = 1'b0;
  logic              ks_ready = 1'b0;
  logic              busy, core_load, core_clear, core_init_mode, core_step;
  logic              ks_valid, done;
  logic [WORD_W-1:0] core_z, ks_data;

  snow3g_ks_ctrl #(.INIT_ROUNDS(N_ROUNDS), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .abort(abort),
    .busy(busy), .core_load(core_load), .core_clear(core_clear),
    .core_init_mode(core_init_mode), .core_step(core_step), .core_z(core_z),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_load, n_clear, n_init, n_step, n_xfer, n_done, n_busy;
  int cyc = 0, start_cyc, first_valid_cyc;
  bit seen_valid, prev_stall;
  logic [31:0] prev_data;
  logic [31:0] exp_q[$];
  logic [31:0] seed_r = '0;
  logic [31:0] core_st;
  int ready_mode = 0;
  int pat_idx = 0;
  bit [5:0] pat_bits = 6'b101001; // index 0..5 -> 1,0,0,1,0,1

  function automatic logic [31:0] f_init(input logic [31:0] s);
    return {s[26:0], s[31:27]} + 32'h9E37_79B9;
  endfunction
  function automatic logic [31:0] f_run(input logic [31:0] s);
    return s * 32'd1664525 + 32'd1013904223;
  endfunction
  function automatic logic [31:0] zf(input logic [31:0] s);
    return s ^ {s[15:0], s[31:16]};
  endfunction

  // Stand-in core: reacts only to the controller's strobes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                core_st <= '0;
    else if (core_load)        core_st <= seed_r;
    else if (core_step)        core_st <= core_init_mode ? f_init(core_st) : f_run(core_st);
  end
  assign core_z = zf(core_st);

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ks_ready = 1'b1;
      1:       ks_ready = 1'($urandom_range(0, 1));
      default: begin ks_ready = pat_bits[pat_idx % 6]; pat_idx++; end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      n_load  += int'(core_load);
      n_clear += int'(core_clear);
      n_init  += int'(core_init_mode);
      n_step  += int'(core_step);
      n_done  += int'(done);
      n_busy  += int'(busy);
      if (ks_valid) begin
        if (!seen_valid) begin seen_valid = 1'b1; first_valid_cyc = cyc; end
        check("run_core_step", 32'(core_step), 32'(ks_ready & ~abort));
        if (prev_stall) check("stall_hold", ks_data, prev_data);
        if (ks_ready) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_word actual=%0h expected=none", ks_data);
          end else begin
            check("ks_word", ks_data, exp_q.pop_front());
          end
        end
      end
      prev_stall = ks_valid && !ks_ready;
      prev_data  = ks_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_counts();
    n_load = 0; n_clear = 0; n_init = 0; n_step = 0; n_xfer = 0; n_done = 0; n_busy = 0;
    seen_valid = 1'b0; prev_stall = 1'b0; first_valid_cyc = -1;
  endtask

  task automatic push_model(input int n, input logic [31:0] seed);
    logic [31:0] s;
    s = seed;
    for (int i = 0; i < N_ROUNDS; i++) s = f_init(s);
    s = f_run(s); // discarded clock
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(zf(s));
      s = f_run(s);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    i = 0;
    while (busy && i < budget) begin tick(); i++; end
    check(name, 32'(busy), 0);
  endtask

  task automatic run_session(input int n, input int mode, input bit poke, input bit abort_start);
    ready_mode = mode;
    clear_counts();
    seed_r = $urandom;
    push_model(n, seed_r);
    start = 1'b1; num_words = LEN_W'(n); abort = abort_start;
    tick();
    start = 1'b0; abort = 1'b0; num_words = LEN_W'($urandom);
    start_cyc = cyc;
    if (n != 0) begin
      check("load_cycle1", 32'(core_load), 1);
      check("clear_cycle1", 32'(core_clear), 1);
    end
    if (poke) begin
      repeat (5) tick();
      start = 1'b1; num_words = 7;
      tick();
      start = 1'b0;
    end
    wait_idle(60 + n * 40, "session_end");
    tick();
    check("done_count", n_done, 1);
    check("queue_drained", exp_q.size(), 0);
    if (n == 0) begin
      check("zero_load", n_load, 0);
      check("zero_step", n_step, 0);
      check("zero_busy_cycles", n_busy, 1);
    end else begin
      check("load_count", n_load, 1);
      check("clear_count", n_clear, 1);
      check("init_cycles", n_init, N_ROUNDS);
      check("step_count", n_step, N_ROUNDS + 1 + n);
      check("xfer_count", n_xfer, n);
      check("first_valid_latency", first_valid_cyc - start_cyc, N_ROUNDS + 2);
    end
  endtask

  initial begin
    int i;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 32'({busy, core_load, core_clear, core_init_mode, core_step, ks_valid, done}), 0);
    check("reset_data", ks_data, 0);
    rst_n = 1'b1;
    tick();

    // abort alone in IDLE does nothing
    abort = 1'b1; tick(); tick();
    check("abort_idle_busy", 32'(busy), 0);
    abort = 1'b0;

    run_session(4, 0, 1'b0, 1'b0);
    run_session(3, 2, 1'b0, 1'b0);
    run_session(0, 0, 1'b0, 1'b0);

    // abort in INIT round 10
    ready_mode = 0; clear_counts(); seed_r = $urandom;
    start = 1'b1; num_words = 5; tick(); start = 1'b0;
    repeat (11) tick();
    check("abort_init_mode", 32'(core_init_mode), 1);
    abort = 1'b1; #1;
    check("abort_init_step", 32'(core_step), 0);
    tick(); abort = 1'b0;
    check("abort_init_idle", 32'(busy), 0);
    repeat (3) tick();
    check("abort_init_rounds", n_init, 11);
    check("abort_init_nodone", n_done, 0);

    // abort in RUN after 2 of 5 words; the offered word still transfers
    clear_counts(); seed_r = $urandom; push_model(5, seed_r);
    start = 1'b1; num_words = 5; tick(); start = 1'b0;
    i = 0;
    while (n_xfer < 2 && i < 200) begin tick(); i++; end
    check("abort_run_reach", n_xfer, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_run_idle", 32'(busy), 0);
    repeat (3) tick();
    check("abort_run_xfers", n_xfer, 3);
    check("abort_run_nodone", n_done, 0);
    exp_q.delete();

    run_session(5, 0, 1'b0, 1'b0);
    run_session(2, 0, 1'b1, 1'b0);  // start pulsed during INIT
    run_session(3, 0, 1'b0, 1'b1);  // start with abort in IDLE
    for (int k = 0; k < 4; k++) run_session(int'($urandom_range(1, 8)), 1, 1'b0, 1'b0);

    // asynchronous reset mid-RUN
    ready_mode = 0; clear_counts(); seed_r = $urandom; push_model(6, seed_r);
    start = 1'b1; num_words = 6; tick(); start = 1'b0;
    i = 0;
    while (n_xfer < 2 && i < 200) begin tick(); i++; end
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 32'({busy, core_load, core_clear, core_init_mode, core_step, ks_valid, done}), 0);
    check("rst_mid_data", ks_data, 0);
    @(negedge clk);
    exp_q.delete();
    #2 rst_n = 1'b1;
    tick();
    check("rst_mid_idle", 32'(busy), 0);
    run_session(3, 1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
